pipe_ctrl_unit: RTL

- Central stall/flush sequencer for the MiniMIPS32 5-stage pipeline.
- Takes stall requests from ID (load-use) and EXE (multi-cycle divide), plus the exception code from MEM.
- Drives the shared stall vector and flush line consumed by the pc, ifid, idexe and exemem pipeline registers.
- Owns the divide-wait FSM/counter and the PC redirect on exception/ERET.

---
 rtl/pipe_ctrl_unit_pkg.sv | 40 ++++
 rtl/pipe_ctrl_unit_div_timer.sv | 34 +++
 rtl/pipe_ctrl_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the MiniMIPS32 pipeline control unit.
// Covers bus widths, stall vector constants, exception codes and FSM state encoding.
package pipe_ctrl_unit_pkg;

  // Stall vector: [0] pc hold, [1] ifid hold, [2] idexe hold, [3] exemem bubble
  localparam int STALL_W = 4;
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [STALL_W-1:0] STALL_NONE     = {STALL_W{NOSTOP}};
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = {NOSTOP, STOP, STOP, STOP};
  localparam logic [STALL_W-1:0] STALL_ALL      = {STALL_W{STOP}};

  // Exception codes carried down the pipeline from MEM
  localparam int EXC_CODE_W = 5;
  localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'h10;
  localparam logic [EXC_CODE_W-1:0] EXC_ERET = 5'h11;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'h0c;

  // Instruction address bus
  localparam int INST_ADDR_W = 32;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

  // Divide-wait FSM states
  typedef enum logic [1:0] {
    PCU_IDLE     = 2'b00,
    PCU_DIV_BUSY = 2'b01,
    PCU_DIV_DONE = 2'b10
  } pcu_state_e;

  // ERET returns to the saved EPC; every other exception goes to the fixed vector.
  function automatic logic [INST_ADDR_W-1:0] exc_target(
    input logic [EXC_CODE_W-1:0]  code,
    input logic [INST_ADDR_W-1:0] epc,
    input logic [INST_ADDR_W-1:0] vector
  );
    return (code == EXC_ERET) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_div_timer.sv
// Divide watchdog counter: loads a cycle budget, counts down while the divider
// is busy, saturates at zero and reports when the budget is exhausted.
module pcu_div_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Counter register: clear beats load beats decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central stall/flush sequencer for the MiniMIPS32 5-stage pipeline.
// Merges the ID load-use stall, the EXE divide wait and MEM exceptions into one
// stall vector, a flush line and the PC redirect.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int                     DIV_CYCLES = 34,
  parameter logic [INST_ADDR_W-1:0] EXC_VECTOR = 32'h0000_0100
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst_n,
  input  logic                   id_stallreq,
  input  logic                   exe_div_start,
  input  logic                   div_ready,
  input  logic [EXC_CODE_W-1:0]  mem_exccode,
  input  logic [INST_ADDR_W-1:0] cp0_epc,
  output logic [STALL_W-1:0]     stall,
  output logic                   flush,
  output logic                   exc_redirect,
  output logic [INST_ADDR_W-1:0] exc_pc,
  output logic                   div_busy,
  output logic                   div_abort,
  output logic                   div_timeout
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  pcu_state_e       state_reg;
  logic             div_timeout_reg;
  logic             exc;
  logic             timer_load;
  logic             timer_dec;
  logic             timer_zero;
  logic [CNT_W-1:0] timer_count;

  assign exc = (mem_exccode != EXC_NONE);

  // The timer is armed on divide entry, runs only while busy, and is cleared
  // when an exception kills the divide so a stale count never lingers.
  assign timer_load = (state_reg == PCU_IDLE) && !exc && exe_div_start;
  assign timer_dec  = (state_reg == PCU_DIV_BUSY) && !exc;

  pcu_div_timer #(
    .CNT_W (CNT_W)
  ) u_div_timer (
    .clk        (cpu_clk_50M),
    .rst_n      (cpu_rst_n),
    .load       (timer_load),
    .load_value (DIV_LOAD),
    .dec        (timer_dec),
    .clear      (exc),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  // Divide-wait FSM and sticky timeout flag; an exception always returns to IDLE.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg       <= PCU_IDLE;
      div_timeout_reg <= 1'b0;
    end else if (exc) begin
      state_reg <= PCU_IDLE;
    end else begin
      case (state_reg)
        PCU_IDLE: begin
          if (exe_div_start) begin
            state_reg <= PCU_DIV_BUSY;
          end
        end
        PCU_DIV_BUSY: begin
          if (div_ready) begin
            state_reg <= PCU_DIV_DONE;
          end else if (timer_zero) begin
            state_reg       <= PCU_DIV_DONE;
            div_timeout_reg <= 1'b1;
          end
        end
        PCU_DIV_DONE: begin
          state_reg <= PCU_IDLE;
        end
        default: begin
          state_reg <= PCU_IDLE;
        end
      endcase
    end
  end

  // Same-cycle output decode; exceptions override every stall source.
  always_comb begin
    stall        = STALL_NONE;
    flush        = 1'b0;
    exc_redirect = 1'b0;
    exc_pc       = ZERO_WORD;
    div_abort    = 1'b0;
    if (exc) begin
      flush        = 1'b1;
      exc_redirect = 1'b1;
      exc_pc       = exc_target(mem_exccode, cp0_epc, EXC_VECTOR);
      div_abort    = (state_reg == PCU_DIV_BUSY);
    end else begin
      case (state_reg)
        PCU_IDLE: begin
          if (exe_div_start) begin
            stall = STALL_ALL;
          end else if (id_stallreq) begin
            stall = STALL_LOAD_USE;
          end
        end
        PCU_DIV_BUSY: stall = STALL_ALL;
        // DIV_DONE releases the pipe so the divide moves on with its result
        default:      stall = STALL_NONE;
      endcase
    end
  end

  assign div_busy    = (state_reg == PCU_DIV_BUSY);
  assign div_timeout = div_timeout_reg;

endmodule
